// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: coordinates and strobe towards the
// pixel source, returned pixel data, and the sync/colour pin outputs.
interface vga_timing_gen_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10,
    parameter int unsigned CW = 4
);
    logic [3*CW-1:0] pix_rgb_i;
    logic            o_pix_stb;
    logic [XW-1:0]   o_x;
    logic [YW-1:0]   o_y;
    logic            o_active;
    logic            o_line;
    logic            o_frame;
    logic            VGA_HS_O;
    logic            VGA_VS_O;
    logic [CW-1:0]   VGA_R;
    logic [CW-1:0]   VGA_G;
    logic [CW-1:0]   VGA_B;

    modport master (
        input  pix_rgb_i,
        output o_pix_stb, o_x, o_y, o_active, o_line, o_frame,
        output VGA_HS_O, VGA_VS_O, VGA_R, VGA_G, VGA_B
    );

    modport slave (
        output pix_rgb_i,
        input  o_pix_stb, o_x, o_y, o_active, o_line, o_frame,
        input  VGA_HS_O, VGA_VS_O, VGA_R, VGA_G, VGA_B
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: phase-accumulator pixel strobe, h/v counters, and a sync/blank
// delay line that lines the pins up with a pixel source of LAT strobes read latency.
module vga_timing_gen #(
    parameter logic [15:0] STB_INC  = 16'h4000,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned LAT      = 1,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10,
    parameter int unsigned CW       = 4
) (
    input logic               CLK,
    input logic               RST_BTN,
    vga_timing_gen_if.master  vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic pin_level(input logic raw, input logic pol);
        return raw ? pol : ~pol;
    endfunction

    function automatic logic [3*CW-1:0] blank_rgb(input logic vld, input logic [3*CW-1:0] rgb);
        return vld ? rgb : '0;
    endfunction

    logic [15:0]   acc_p0;
    logic [16:0]   acc_sum;
    logic          stb_p0;
    logic [XW-1:0] h_p0, h_nxt;
    logic [YW-1:0] v_p0, v_nxt;
    logic          vld_p0, line_p0, frame_p0;

    assign acc_sum = {1'b0, acc_p0} + {1'b0, STB_INC};

    always_comb begin
        h_nxt = h_p0 + 1'b1;
        v_nxt = v_p0;
        if (h_p0 == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_p0 == V_LAST) ? '0 : v_p0 + 1'b1;
        end
    end

    // Stage p0: strobe and coordinate counters
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            acc_p0   <= '0;
            stb_p0   <= 1'b0;
            h_p0     <= H_LAST;
            v_p0     <= V_LAST;
            vld_p0   <= 1'b0;
            line_p0  <= 1'b0;
            frame_p0 <= 1'b0;
        end else begin
            {stb_p0, acc_p0} <= acc_sum;
            line_p0          <= 1'b0;
            frame_p0         <= 1'b0;
            if (stb_p0) begin
                h_p0     <= h_nxt;
                v_p0     <= v_nxt;
                vld_p0   <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
                line_p0  <= (h_nxt == '0);
                frame_p0 <= (h_nxt == '0) && (v_nxt == '0);
            end
        end
    end

    // Raw sync of the current coordinate, packed {hs, vs, vld}; sync levels applied at the pins
    logic [2:0] cur_p0;
    logic [2:0] tap;
    assign cur_p0 = {(h_p0 >= HS_BEG) && (h_p0 < HS_END),
                     (v_p0 >= VS_BEG) && (v_p0 < VS_END),
                     vld_p0};

    generate
        if (LAT > 1) begin : g_dly
            logic [2:0] dly_p [LAT-1];
            always_ff @(posedge CLK or negedge RST_BTN) begin
                if (!RST_BTN) begin
                    for (int i = 0; i < int'(LAT) - 1; i++) dly_p[i] <= '0;
                end else if (stb_p0) begin
                    dly_p[0] <= cur_p0;
                    for (int i = 1; i < int'(LAT) - 1; i++) dly_p[i] <= dly_p[i-1];
                end
            end
            assign tap = dly_p[LAT-2];
        end else begin : g_nodly
            assign tap = cur_p0;
        end
    endgenerate

    // Stage p1: pin register, updated on strobes so inter-strobe pixel changes are ignored
    logic            hs_p1, vs_p1;
    logic [3*CW-1:0] rgb_p1;

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            hs_p1  <= ~HS_POL;
            vs_p1  <= ~VS_POL;
            rgb_p1 <= '0;
        end else if (stb_p0) begin
            hs_p1  <= pin_level(tap[2], HS_POL);
            vs_p1  <= pin_level(tap[1], VS_POL);
            rgb_p1 <= blank_rgb(tap[0], vga.pix_rgb_i);
        end
    end

    assign vga.o_pix_stb = stb_p0;
    assign vga.o_x       = h_p0;
    assign vga.o_y       = v_p0;
    assign vga.o_active  = vld_p0;
    assign vga.o_line    = line_p0;
    assign vga.o_frame   = frame_p0;
    assign vga.VGA_HS_O  = hs_p1;
    assign vga.VGA_VS_O  = vs_p1;
    assign vga.VGA_R     = rgb_p1[3*CW-1:2*CW];
    assign vga.VGA_G     = rgb_p1[2*CW-1:CW];
    assign vga.VGA_B     = rgb_p1[CW-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three small-geometry instances (LAT=1, LAT=3 with a coordinate
// echoing source, inverted sync polarity) compared every cycle to a closed-form model.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 3, HT = HA + HF + HSW + HB;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 1, VT = VA + VF + VSW + VB;
    localparam longint INC = 16384;

    typedef struct packed {
        logic        stb;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        act;
        logic        line;
        logic        frame;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    logic CLK;
    logic RST_BTN;

    vga_timing_gen_if #(.XW(10), .YW(10), .CW(4)) if1 ();
    vga_timing_gen_if #(.XW(10), .YW(10), .CW(4)) if2 ();
    vga_timing_gen_if #(.XW(10), .YW(10), .CW(4)) if3 ();

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                     .HS_POL(1'b0), .VS_POL(1'b0), .LAT(1))
        dut1 (.CLK(CLK), .RST_BTN(RST_BTN), .vga(if1));

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                     .HS_POL(1'b0), .VS_POL(1'b0), .LAT(3))
        dut2 (.CLK(CLK), .RST_BTN(RST_BTN), .vga(if2));

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                     .HS_POL(1'b1), .VS_POL(1'b1), .LAT(1))
        dut3 (.CLK(CLK), .RST_BTN(RST_BTN), .vga(if3));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    endtask

    // Model: k = rising edges since reset release; strobes follow accumulator carries.
    function automatic longint n_of(input longint k);
        return (k < 1) ? 0 : (((k - 1) * INC) >> 16);
    endfunction

    function automatic bit stb_of(input longint k);
        return (k >= 1) && (((k * INC) >> 16) != (((k - 1) * INC) >> 16));
    endfunction

    function automatic void coord(input longint p, output int x, output int y);
        if (p < 0) begin
            x = HT - 1;
            y = VT - 1;
        end else begin
            x = int'(p % HT);
            y = int'((p / HT) % VT);
        end
    endfunction

    function automatic logic [11:0] enc_of(input longint p);
        int x, y;
        logic [3:0] xs, ys;
        coord(p, x, y);
        xs = 4'(x);
        ys = 4'(y);
        return {xs, ys, 4'h5};
    endfunction

    function automatic exp_t model(input longint k, input int lat, input bit hpol, input bit vpol,
                                   input bit echo, input logic [11:0] cap);
        exp_t   e;
        longint n, q;
        int     x, y;
        bit     hr, vr, ta;
        n     = n_of(k);
        e.stb = stb_of(k);
        if (n == 0) begin
            e.x = 10'(HT - 1); e.y = 10'(VT - 1);
            e.act = 0; e.line = 0; e.frame = 0;
            e.hs = ~hpol; e.vs = ~vpol; e.rgb = '0;
            return e;
        end
        coord(n - 1, x, y);
        e.x     = 10'(x);
        e.y     = 10'(y);
        e.act   = (x < HA) && (y < VA);
        e.line  = stb_of(k - 1) && (x == 0);
        e.frame = e.line && (y == 0);
        q = n - 1 - lat;
        if (q < -1) begin
            hr = 0; vr = 0; ta = 0;
        end else begin
            coord(q, x, y);
            hr = (x >= HA + HF) && (x < HA + HF + HSW);
            vr = (y >= VA + VF) && (y < VA + VF + VSW);
            ta = (x < HA) && (y < VA);
        end
        e.hs  = hr ? hpol : ~hpol;
        e.vs  = vr ? vpol : ~vpol;
        e.rgb = ta ? (echo ? enc_of(q) : cap) : 12'h000;
        return e;
    endfunction

    task automatic chk_inst(input string nm, input exp_t e,
                            input logic stb, input logic [9:0] x, input logic [9:0] y,
                            input logic act, input logic line, input logic frame,
                            input logic hs, input logic vs, input logic [11:0] rgb);
        check_val({nm, ".stb"}, 32'(stb), 32'(e.stb));
        check_val({nm, ".x"}, 32'(x), 32'(e.x));
        check_val({nm, ".y"}, 32'(y), 32'(e.y));
        check_val({nm, ".active"}, 32'(act), 32'(e.act));
        check_val({nm, ".line"}, 32'(line), 32'(e.line));
        check_val({nm, ".frame"}, 32'(frame), 32'(e.frame));
        check_val({nm, ".hs"}, 32'(hs), 32'(e.hs));
        check_val({nm, ".vs"}, 32'(vs), 32'(e.vs));
        check_val({nm, ".rgb"}, 32'(rgb), 32'(e.rgb));
    endtask

    longint      k = 0;
    logic [11:0] cap1 = '0;
    logic [11:0] cap3 = '0;

    // Edge counter and capture of the pixel the pins should show after each strobe update
    always @(posedge CLK) begin
        if (!RST_BTN) k = 0;
        else begin
            k = k + 1;
            if (stb_of(k - 1)) begin
                cap1 = if1.pix_rgb_i;
                cap3 = if3.pix_rgb_i;
            end
        end
    end

    task automatic check_all();
        chk_inst("lat1", model(k, 1, 1'b0, 1'b0, 1'b0, cap1),
                 if1.o_pix_stb, if1.o_x, if1.o_y, if1.o_active, if1.o_line, if1.o_frame,
                 if1.VGA_HS_O, if1.VGA_VS_O, {if1.VGA_R, if1.VGA_G, if1.VGA_B});
        chk_inst("lat3", model(k, 3, 1'b0, 1'b0, 1'b1, 12'h000),
                 if2.o_pix_stb, if2.o_x, if2.o_y, if2.o_active, if2.o_line, if2.o_frame,
                 if2.VGA_HS_O, if2.VGA_VS_O, {if2.VGA_R, if2.VGA_G, if2.VGA_B});
        chk_inst("pol1", model(k, 1, 1'b1, 1'b1, 1'b0, cap3),
                 if3.o_pix_stb, if3.o_x, if3.o_y, if3.o_active, if3.o_line, if3.o_frame,
                 if3.VGA_HS_O, if3.VGA_VS_O, {if3.VGA_R, if3.VGA_G, if3.VGA_B});
    endtask

    task automatic drive_pix();
        longint n;
        n = n_of(k);
        if1.pix_rgb_i = 12'($urandom);
        if3.pix_rgb_i = 12'($urandom);
        if2.pix_rgb_i = (n - 3 >= 0) ? enc_of(n - 3) : 12'($urandom);
    endtask

    bit did_rst = 0;
    int hold    = 0;

    initial begin
        int     x, y;
        longint n;
        RST_BTN       = 1'b0;
        if1.pix_rgb_i = '0;
        if2.pix_rgb_i = '0;
        if3.pix_rgb_i = '0;
        repeat (3) begin
            @(negedge CLK);
            check_all();
        end
        RST_BTN = 1'b1;
        for (int cyc = 0; cyc < 3200; cyc++) begin
            @(negedge CLK);
            check_all();
            n = n_of(k);
            coord(n - 1, x, y);
            if (!did_rst && RST_BTN && k > 600 && n > 0 && x == 5 && y == 2) begin
                RST_BTN = 1'b0;
                #1;
                check_val("async.x", 32'(if1.o_x), 32'(HT - 1));
                check_val("async.y", 32'(if1.o_y), 32'(VT - 1));
                check_val("async.active", 32'(if1.o_active), 32'd0);
                check_val("async.rgb", 32'({if1.VGA_R, if1.VGA_G, if1.VGA_B}), 32'd0);
                check_val("async.hs", 32'(if1.VGA_HS_O), 32'd1);
                check_val("async.lat3_x", 32'(if2.o_x), 32'(HT - 1));
                check_val("async.lat3_vs", 32'(if2.VGA_VS_O), 32'd1);
                check_val("async.pol1_hs", 32'(if3.VGA_HS_O), 32'd0);
                check_val("async.pol1_vs", 32'(if3.VGA_VS_O), 32'd0);
                did_rst = 1;
                hold    = 4;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) RST_BTN = 1'b1;
            end
            drive_pix();
        end
        check_val("mid_reset_reached", 32'(did_rst), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator with an integrated pixel-strobe divider, programmable sync polarity and a latency-matched RGB output stage. It sits between the board pins and the frame-buffer/BRAM pixel source. It produces pixel coordinates for the source and delays sync and blanking by a configurable number of pixel strobes so that pin timing lines up with the source's read latency.

## Interface
- STB_INC, 16'h4000: phase-accumulator increment; strobe rate = CLK·STB_INC/2^16 (default 25 MHz from 100 MHz)
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal front porch, sync width, back porch (pixels)
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical front porch, sync width, back porch (lines)
- HS_POL, 0 / VS_POL, 0: sync active level (0 = active-low)
- LAT, 1: pixel-source latency in strobes, legal range 1..8
- XW, 10 / YW, 10: coordinate widths; must hold H_TOTAL-1 and V_TOTAL-1
- CW, 4: bits per colour channel
- CLK  in  1  system clock; all state on rising edge
- RST_BTN  in  1  asynchronous, active-low reset
- pix_rgb_i  in  3·CW  pixel from source, packed {R,G,B}
- o_pix_stb  out  1  one-CLK pixel strobe
- o_x  out  XW  current horizontal count
- o_y  out  YW  current vertical count
- o_active  out  1  (o_x,o_y) inside the visible region
- o_line  out  1  one-CLK pulse when o_x becomes 0
- o_frame  out  1  one-CLK pulse when (o_x,o_y) becomes (0,0)
- VGA_HS_O, VGA_VS_O  out  1  sync to pins
- VGA_R, VGA_G, VGA_B  out  CW  colour to pins

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. Line and frame order: active, front porch, sync, back porch.
- Strobe: a 16-bit accumulator adds STB_INC every CLK. The carry-out is registered as o_pix_stb, giving exactly one CLK high per carry.
- Counters advance only on edges where o_pix_stb=1. h wraps H_TOTAL-1→0 and increments v. v wraps V_TOTAL-1→0 only when h wraps.
- o_active is registered with the counters: high iff h<H_ACTIVE and v<V_ACTIVE.
- o_line and o_frame are set on the counter-update edge that enters h=0 or (0,0). They clear on the next CLK edge.
- Raw hsync is true for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC. Vsync uses the same rule on v. Both are driven at pin level HS_POL or VS_POL when true.
- Delay line: {hs, vs, active} for the current coordinate pass through LAT-1 strobe-enabled stages, then the output register.
- Output register, on strobe edges only:
  - VGA_HS_O and VGA_VS_O take the delayed sync.
  - VGA_R/G/B take pix_rgb_i when the delayed active is 1, otherwise 0.
- Source contract: RGB for coordinate (x,y) must be valid on pix_rgb_i at the LAT-th strobe edge after the edge where o_x/o_y became (x,y).
- Reset (asynchronous):
  - Accumulator = 0, o_pix_stb = 0.
  - h = H_TOTAL-1, v = V_TOTAL-1, so o_x/o_y reset to those values.
  - o_active, o_line, o_frame = 0.
  - Delay stages hold inactive values.
  - VGA_HS_O = ~HS_POL, VGA_VS_O = ~VS_POL, RGB = 0.
- Reset mid-frame: all state returns to the reset values immediately. The first strobe after release moves to (0,0) and pulses o_frame.

## Timing
- With the default STB_INC, o_pix_stb is high 1 of every 4 CLK. The first o_pix_stb is 4 CLK after reset release (accumulator must carry).
- o_x/o_y/o_active/o_line/o_frame change only on strobe edges: 0 CLK latency from the strobe.
- Pins lag the coordinate outputs by exactly LAT strobe intervals (LAT·4 CLK at default).
- A pix_rgb_i change between strobe edges has no effect on the pins.
- Line period is H_TOTAL strobes and frame period is H_TOTAL·V_TOTAL strobes (default 800 × 525).

## Test plan
- Small params for all scenarios: H = 8/2/3/3 (total 16), V = 4/1/2/1 (total 8), default STB_INC, LAT=1.
- Strobe and reset: release reset → o_pix_stb every 4th CLK. First strobe gives o_x=0, o_y=0, o_frame pulse 1 CLK wide, o_active=1. Before that: o_x=15, o_y=7, HS/VS high, RGB 0.
- Horizontal sync: VGA_HS_O low for exactly 3 strobes, covering coordinates h=10..12, appearing 1 strobe after o_x reaches those values. Sync edges occur at o_x 11 and 14 (h=10..12 shown one strobe late); o_line pulses every 16 strobes.
- Vertical wrap and blanking: VGA_VS_O low only during lines 5–6. With pix_rgb_i held at 12'hFFF, RGB is 0 for h≥8 or v≥4 and FFF otherwise. o_frame pulses every 128 strobes.
- Latency LAT=3: source returns {x[3:0], y[3:0], 4'h5} delayed 3 strobes → each pin pixel shows its matching coordinate. HS low window is shifted by 3 strobes relative to o_x.
- Mid-frame reset at (5,2): outputs return to reset values asynchronously within the same CLK. After release the frame restarts at (0,0) with o_frame.
- Polarity HS_POL=1, VS_POL=1: idle/reset level low, sync pulses high, same widths as the active-low case.
